// File: rtl/key_debouncer_pkg.sv
// Shared types and elaboration-time helpers for the key debouncer.
// The repeat-state encoding lives here so every channel uses the same values.
package key_debouncer_pkg;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_e;

   // Width of a counter that must hold 0 .. n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Key-pin and conditioned-output bundle between the board pins and the PIO/game logic.
// The master drives the raw pins; the slave (the debouncer) drives the clean outputs.
interface key_debouncer_if #(
   parameter int NUM_KEYS = 4
);

   logic [NUM_KEYS-1:0] key_n_in;
   logic [NUM_KEYS-1:0] buttons_out;
   logic [NUM_KEYS-1:0] press_pulse;
   logic [NUM_KEYS-1:0] release_pulse;
   logic [NUM_KEYS-1:0] repeat_pulse;

   modport master (
      output key_n_in,
      input  buttons_out,
      input  press_pulse,
      input  release_pulse,
      input  repeat_pulse
   );

   modport slave (
      input  key_n_in,
      output buttons_out,
      output press_pulse,
      output release_pulse,
      output repeat_pulse
   );

endinterface

// File: rtl/key_debounce_channel.sv
// One key: two-flop synchroniser, debounce counter and auto-repeat FSM.
// All outputs are registered; the strobes rise on the same edge as the stable level changes.
module key_debounce_channel
   import key_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES      = 500000,
   parameter int REPEAT_DELAY_CYCLES  = 25000000,
   parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
   input  logic clk_clk,
   input  logic reset_reset_n,
   input  logic key_n_in,
   output logic buttons_out,
   output logic press_pulse,
   output logic release_pulse,
   output logic repeat_pulse
);

   localparam int CNT_W  = cnt_width(DEBOUNCE_CYCLES);
   localparam int RCNT_W = cnt_width(max_int(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES));

   localparam logic [CNT_W-1:0]  DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD_CYCLES - 1);

   localparam logic [1:0] ST_IDLE   = RPT_IDLE;
   localparam logic [1:0] ST_DELAY  = RPT_DELAY;
   localparam logic [1:0] ST_REPEAT = RPT_REPEAT;

   logic              s1_q, s1_d;
   logic              s2_q, s2_d;
   logic              stable_q, stable_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              press_q, press_d;
   logic              release_q, release_d;
   logic              repeat_q, repeat_d;
   logic [1:0]        state_q, state_d;
   logic [RCNT_W-1:0] rcnt_q, rcnt_d;
   logic              accept;

   // Debounce: the counter runs only while the synchronised level disagrees with stable.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      s1_d     = key_n_in;
      s2_d     = s1_q;
      stable_d = stable_q;
      cnt_d    = '0;
      accept   = 1'b0;
      if (s2_q != stable_q) begin
         if (cnt_q == DB_LAST) begin
            accept   = 1'b1;
            stable_d = s2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      press_d   = accept & ~s2_q;
      release_d = accept & s2_q;
   end

   // A release ends the hold on its own edge, pre-empting a repeat due on that same edge.
   always_comb begin
      state_d  = state_q;
      rcnt_d   = rcnt_q;
      repeat_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (press_d) begin
               state_d = ST_DELAY;
               rcnt_d  = '0;
            end
         end
         ST_DELAY: begin
            if (release_d) begin
               state_d = ST_IDLE;
               rcnt_d  = '0;
            end else if (rcnt_q == DELAY_LAST) begin
               repeat_d = 1'b1;
               rcnt_d   = '0;
               state_d  = ST_REPEAT;
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         ST_REPEAT: begin
            if (release_d) begin
               state_d = ST_IDLE;
               rcnt_d  = '0;
            end else if (rcnt_q == PERIOD_LAST) begin
               repeat_d = 1'b1;
               rcnt_d   = '0;
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk_clk) begin
      // NOTE: reset is sampled on the clock edge; every register here, counters included, gets a reset value.
      if (!reset_reset_n) begin
         s1_q      <= 1'b1;
         s2_q      <= 1'b1;
         stable_q  <= 1'b1;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         repeat_q  <= 1'b0;
         state_q   <= ST_IDLE;
         rcnt_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values together.
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         stable_q  <= stable_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
         repeat_q  <= repeat_d;
         state_q   <= state_d;
         rcnt_q    <= rcnt_d;
      end
   end

   assign buttons_out   = stable_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/key_debouncer.sv
// Conditions the raw active-low KEY pins for the buttons_export PIO and game-control logic.
// Each key is an independent channel; the top only fans the bundle out and back in.
module key_debouncer #(
   parameter int NUM_KEYS             = 4,
   parameter int DEBOUNCE_CYCLES      = 500000,
   parameter int REPEAT_DELAY_CYCLES  = 25000000,
   parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
   input logic             clk_clk,
   input logic             reset_reset_n,
   key_debouncer_if.slave  keys
);

   logic [NUM_KEYS-1:0] buttons_w;
   logic [NUM_KEYS-1:0] press_w;
   logic [NUM_KEYS-1:0] release_w;
   logic [NUM_KEYS-1:0] repeat_w;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
      key_debounce_channel #(
         .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
         .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
         .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
      ) u_ch (
         .clk_clk       (clk_clk),
         .reset_reset_n (reset_reset_n),
         .key_n_in      (keys.key_n_in[i]),
         .buttons_out   (buttons_w[i]),
         .press_pulse   (press_w[i]),
         .release_pulse (release_w[i]),
         .repeat_pulse  (repeat_w[i])
      );
   end

   assign keys.buttons_out   = buttons_w;
   assign keys.press_pulse   = press_w;
   assign keys.release_pulse = release_w;
   assign keys.repeat_pulse  = repeat_w;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed scenarios plus random key activity, all checked
// against a window-based reference model that tracks raw pin history per key.
module tb_key_debouncer;

   localparam int K  = 4;
   localparam int DB = 8;
   localparam int RD = 20;
   localparam int RP = 5;

   logic clk_clk = 1'b0;
   logic reset_reset_n;
   always #5 clk_clk = ~clk_clk;

   key_debouncer_if #(.NUM_KEYS(K)) kif ();

   key_debouncer #(
      .NUM_KEYS             (K),
      .DEBOUNCE_CYCLES      (DB),
      .REPEAT_DELAY_CYCLES  (RD),
      .REPEAT_PERIOD_CYCLES (RP)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .keys          (kif)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: a level is accepted once the synchronised pin has disagreed with
   // the current level for DB consecutive samples; repeats fall at fixed offsets from the press.
   logic [K-1:0] m_s1, m_stable, m_held;
   logic [K-1:0] m_win [DB];
   int           m_edge = 0;
   int           m_press_edge [K];
   logic [K-1:0] exp_buttons, exp_press, exp_release, exp_repeat;

   always @(posedge clk_clk) begin : model_blk
      bit all_diff;
      int d;
      m_edge++;
      exp_press   = '0;
      exp_release = '0;
      exp_repeat  = '0;
      if (!reset_reset_n) begin
         m_s1     = '1;
         m_stable = '1;
         m_held   = '0;
         for (int j = 0; j < DB; j++) m_win[j] = '1;
      end else begin
         for (int k = 0; k < K; k++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++)
               if (m_win[j][k] == m_stable[k]) all_diff = 1'b0;
            if (all_diff) begin
               m_stable[k] = ~m_stable[k];
               if (!m_stable[k]) begin
                  exp_press[k]    = 1'b1;
                  m_held[k]       = 1'b1;
                  m_press_edge[k] = m_edge;
               end else begin
                  exp_release[k] = 1'b1;
                  m_held[k]      = 1'b0;
               end
            end else if (m_held[k]) begin
               d = m_edge - m_press_edge[k];
               if (d >= RD && (d - RD) % RP == 0) exp_repeat[k] = 1'b1;
            end
         end
         for (int j = DB - 1; j > 0; j--) m_win[j] = m_win[j-1];
         m_win[0] = m_s1;
         m_s1     = kif.key_n_in;
      end
      exp_buttons = m_stable;
   end

   wire  [4*K-1:0] dut_vec = {kif.buttons_out, kif.press_pulse, kif.release_pulse, kif.repeat_pulse};
   logic [4*K-1:0] exp_vec;
   assign exp_vec = {exp_buttons, exp_press, exp_release, exp_repeat};

   task automatic test_reset();
      int found = -1;
      int n_press = 0;
      reset_reset_n = 1'b0;
      kif.key_n_in  = '0;
      repeat (3) begin
         @(negedge clk_clk);
         total++;
         if (kif.buttons_out !== 4'b1111 || {kif.press_pulse, kif.release_pulse, kif.repeat_pulse} !== 12'h000) begin
            bad++;
            $display("FAIL reset_hold got btn=%b pulses=%b want btn=1111 pulses=0", kif.buttons_out,
                     {kif.press_pulse, kif.release_pulse, kif.repeat_pulse});
         end
      end
      reset_reset_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL reset_model c=%0d got=%b want=%b", c, dut_vec, exp_vec);
         end
         if (kif.press_pulse == 4'b1111) begin
            n_press++;
            if (found < 0) found = c;
         end
      end
      total++;
      if (found != 9 || n_press != 1) begin
         bad++;
         $display("FAIL reset_press_latency got edge=%0d count=%0d want edge=9 count=1", found, n_press);
      end
      total++;
      if (kif.buttons_out !== 4'b0000) begin
         bad++;
         $display("FAIL reset_buttons got=%b want=0000", kif.buttons_out);
      end
      kif.key_n_in = '1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk_clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL reset_settle c=%0d got=%b want=%b", c, dut_vec, exp_vec);
         end
      end
   endtask

   // Seven low cycles must be ignored; eight low cycles is the shortest accepted press.
   task automatic test_glitch();
      int n_press7 = 0, n_low7 = 0, n_press8 = 0, at8 = -1;
      for (int c = 0; c < 30; c++) begin
         kif.key_n_in[0] = (c < 7) ? 1'b0 : 1'b1;
         @(negedge clk_clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL glitch7_model c=%0d got=%b want=%b", c, dut_vec, exp_vec);
         end
         if (kif.press_pulse[0]) n_press7++;
         if (kif.buttons_out[0] !== 1'b1) n_low7++;
      end
      total++;
      if (n_press7 != 0 || n_low7 != 0) begin
         bad++;
         $display("FAIL glitch7 got presses=%0d low_cycles=%0d want 0 and 0", n_press7, n_low7);
      end
      for (int c = 0; c < 30; c++) begin
         kif.key_n_in[0] = (c < 8) ? 1'b0 : 1'b1;
         @(negedge clk_clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL glitch8_model c=%0d got=%b want=%b", c, dut_vec, exp_vec);
         end
         if (kif.press_pulse[0]) begin
            n_press8++;
            at8 = c;
         end
      end
      total++;
      if (n_press8 != 1 || at8 != 9) begin
         bad++;
         $display("FAIL glitch8 got presses=%0d at=%0d want 1 at 9", n_press8, at8);
      end
   endtask

   task automatic test_hold_repeat();
      int press_at = -1, rel_at = -1, n_rpt2 = 0, rpt2_at = -1;
      int rpts[$];
      kif.key_n_in = 4'b1101;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk_clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL hold_model c=%0d got=%b want=%b", c, dut_vec, exp_vec);
         end
         if (kif.press_pulse[1]) press_at = c;
         if (kif.repeat_pulse[1]) rpts.push_back(c);
      end
      total++;
      if (press_at != 9) begin
         bad++;
         $display("FAIL hold_press got=%0d want=9", press_at);
      end
      total++;
      if (rpts.size() != 4) begin
         bad++;
         $display("FAIL hold_repeat_count got=%0d want=4", rpts.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (rpts[i] != 29 + 5 * i) begin
               bad++;
               $display("FAIL hold_repeat_time idx=%0d got=%0d want=%0d", i, rpts[i], 29 + 5 * i);
            end
         end
      end
      kif.key_n_in = '1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk_clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL hold_release_model c=%0d got=%b want=%b", c, dut_vec, exp_vec);
         end
         if (kif.release_pulse[1]) rel_at = c;
         if (kif.repeat_pulse[1]) begin
            n_rpt2++;
            rpt2_at = c;
         end
      end
      // One repeat is still due before acceptance; the one coinciding with the release is dropped.
      total++;
      if (rel_at != 9 || n_rpt2 != 1 || rpt2_at != 4) begin
         bad++;
         $display("FAIL hold_release got rel=%0d repeats=%0d last=%0d want rel=9 repeats=1 last=4",
                  rel_at, n_rpt2, rpt2_at);
      end
   endtask

   task automatic test_bounce();
      int n_press = 0, press_at = -1;
      for (int c = 0; c < 60; c++) begin
         kif.key_n_in[2] = (c < 30) ? (((c / 3) % 2) != 0) : 1'b0;
         @(negedge clk_clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL bounce_model c=%0d got=%b want=%b", c, dut_vec, exp_vec);
         end
         if (kif.press_pulse[2]) begin
            n_press++;
            press_at = c;
         end
      end
      total++;
      if (n_press != 1 || press_at != 39) begin
         bad++;
         $display("FAIL bounce_press got count=%0d at=%0d want count=1 at=39", n_press, press_at);
      end
      kif.key_n_in = '1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk_clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL bounce_settle c=%0d got=%b want=%b", c, dut_vec, exp_vec);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [K-1:0] p9 = '0, r24 = '0, t29 = '0, t34 = '0;
      for (int c = 0; c < 50; c++) begin
         kif.key_n_in = (c >= 15) ? 4'b1000 : 4'b0000;
         @(negedge clk_clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL simul_model c=%0d got=%b want=%b", c, dut_vec, exp_vec);
         end
         if (c == 9)  p9  = kif.press_pulse;
         if (c == 24) r24 = kif.release_pulse;
         if (c == 29) t29 = kif.repeat_pulse;
         if (c == 34) t34 = kif.repeat_pulse;
      end
      total++;
      if (p9 !== 4'b1111 || r24 !== 4'b1000) begin
         bad++;
         $display("FAIL simul_edges got press=%b release=%b want press=1111 release=1000", p9, r24);
      end
      total++;
      if (t29 !== 4'b0111 || t34 !== 4'b0111) begin
         bad++;
         $display("FAIL simul_repeat got r29=%b r34=%b want 0111 0111", t29, t34);
      end
      kif.key_n_in = '1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk_clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL simul_settle c=%0d got=%b want=%b", c, dut_vec, exp_vec);
         end
      end
   endtask

   task automatic test_reset_mid_repeat();
      int press_at = -1, first_rpt = -1;
      kif.key_n_in = 4'b1110;
      for (int c = 0; c < 32; c++) begin
         @(negedge clk_clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL midrst_pre_model c=%0d got=%b want=%b", c, dut_vec, exp_vec);
         end
      end
      reset_reset_n = 1'b0;
      @(negedge clk_clk);
      total++;
      if (kif.buttons_out !== 4'b1111 || {kif.press_pulse, kif.release_pulse, kif.repeat_pulse} !== 12'h000) begin
         bad++;
         $display("FAIL midrst_state got btn=%b pulses=%b want btn=1111 pulses=0", kif.buttons_out,
                  {kif.press_pulse, kif.release_pulse, kif.repeat_pulse});
      end
      reset_reset_n = 1'b1;
      for (int c = 0; c < 35; c++) begin
         @(negedge clk_clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL midrst_post_model c=%0d got=%b want=%b", c, dut_vec, exp_vec);
         end
         if (kif.press_pulse[0] && press_at < 0) press_at = c;
         if (kif.repeat_pulse[0] && first_rpt < 0) first_rpt = c;
      end
      total++;
      if (press_at != 9 || first_rpt != 29) begin
         bad++;
         $display("FAIL midrst_repress got press=%0d repeat=%0d want press=9 repeat=29", press_at, first_rpt);
      end
      kif.key_n_in = '1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk_clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL midrst_settle c=%0d got=%b want=%b", c, dut_vec, exp_vec);
         end
      end
   endtask

   // Mixed short glitches and long holds on every key, with occasional one-cycle resets.
   task automatic test_random();
      int run_left [K];
      for (int k = 0; k < K; k++) run_left[k] = 0;
      for (int c = 0; c < 1500; c++) begin
         reset_reset_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         for (int k = 0; k < K; k++) begin
            if (run_left[k] == 0) begin
               kif.key_n_in[k] = ~kif.key_n_in[k];
               run_left[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(20, 45))
                                                          : int'($urandom_range(1, 12));
            end
            run_left[k]--;
         end
         @(negedge clk_clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL random_model c=%0d got=%b want=%b", c, dut_vec, exp_vec);
         end
      end
      reset_reset_n = 1'b1;
      kif.key_n_in  = '1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk_clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL random_settle c=%0d got=%b want=%b", c, dut_vec, exp_vec);
         end
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_hold_repeat();
      test_bounce();
      test_simultaneous();
      test_reset_mid_repeat();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
